// File: rtl/apu_env_len_unit.sv
// Per-channel envelope generator and length counter driven by the frame counter strobes.
// Optional macro APU_LC_STATUS_EN drives the length-counter status onto DB on a $4015 read.
module apu_env_len_unit #(
    parameter int EN_BIT = 0
) (
    input  logic       ACLK,
    input  logic       RES,
    input  logic       nLFO1,
    input  logic       nLFO2,
    inout  wire  [7:0] DB,
    input  logic       W_CTL,
    input  logic       W_LEN,
    input  logic       W4015,
    input  logic       n_R4015,
    output logic [3:0] VOL,
    output logic       LC_NZ,
    output logic       NOSQ
);

    // ENV_START is the pending start flag: the next quarter frame reloads the envelope.
    typedef enum logic {
        ENV_RUN   = 1'b0,
        ENV_START = 1'b1
    } env_state_t;

    env_state_t env_state_reg, env_state_next;
    logic       halt_reg, halt_next;
    logic       const_reg, const_next;
    logic [3:0] per_reg, per_next;
    logic [3:0] div_reg, div_next;
    logic [3:0] decay_reg, decay_next;
    logic [7:0] lc_reg, lc_next;
    logic       ena_reg, ena_next;

    logic [7:0] db_in;
    logic       qtr_frame;
    logic       half_frame;

    assign db_in      = DB;
    assign qtr_frame  = ~nLFO1;
    assign half_frame = ~nLFO2;

    function automatic logic [7:0] ltab(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        return v;
    endfunction

    // Envelope: every quarter frame either restarts or clocks the divider.
    always_comb begin
        env_state_next = env_state_reg;
        div_next       = div_reg;
        decay_next     = decay_reg;
        if (qtr_frame) begin
            case (env_state_reg)
                ENV_START: begin
                    env_state_next = ENV_RUN;
                    decay_next     = 4'd15;
                    div_next       = per_reg;
                end
                default: begin
                    if (div_reg != 4'd0) begin
                        div_next = div_reg - 4'd1;
                    end else begin
                        div_next = per_reg;
                        if (decay_reg != 4'd0)
                            decay_next = decay_reg - 4'd1;
                        else if (halt_reg)
                            decay_next = 4'd15;
                    end
                end
            endcase
        end
        // A length write re-arms the start even if this edge consumed the old one.
        if (W_LEN)
            env_state_next = ENV_START;
    end

    // Control register, enable and length counter; later assignments take priority.
    always_comb begin
        halt_next  = halt_reg;
        const_next = const_reg;
        per_next   = per_reg;
        ena_next   = ena_reg;
        lc_next    = lc_reg;
        if (W_CTL) begin
            halt_next  = db_in[5];
            const_next = db_in[4];
            per_next   = db_in[3:0];
        end
        if (half_frame && !halt_reg && lc_reg != 8'd0)
            lc_next = lc_reg - 8'd1;
        if (W_LEN && ena_reg)
            lc_next = ltab(db_in[7:3]);
        if (W4015) begin
            ena_next = db_in[EN_BIT];
            if (!db_in[EN_BIT])
                lc_next = 8'd0;
        end
    end

    always_ff @(posedge ACLK or posedge RES) begin
        if (RES) begin
            env_state_reg <= ENV_RUN;
            halt_reg      <= 1'b0;
            const_reg     <= 1'b0;
            per_reg       <= 4'd0;
            div_reg       <= 4'd0;
            decay_reg     <= 4'd0;
            lc_reg        <= 8'd0;
            ena_reg       <= 1'b0;
        end else begin
            env_state_reg <= env_state_next;
            halt_reg      <= halt_next;
            const_reg     <= const_next;
            per_reg       <= per_next;
            div_reg       <= div_next;
            decay_reg     <= decay_next;
            lc_reg        <= lc_next;
            ena_reg       <= ena_next;
        end
    end

    assign VOL   = const_reg ? per_reg : decay_reg;
    assign LC_NZ = (lc_reg != 8'd0);
    assign NOSQ  = ~LC_NZ;

`ifdef APU_LC_STATUS_EN
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_status
            if (gi == EN_BIT) begin : g_drv
                assign DB[gi] = n_R4015 ? 1'bz : LC_NZ;
            end
        end
    endgenerate
`else
    logic unused_rd;
    assign unused_rd = n_R4015;
`endif

endmodule
